// File: rtl/lif_pkg.sv
// Shared types, default widths and arithmetic helpers for the leaky integrate-and-fire neuron.
package lif_pkg;

    typedef enum logic [0:0] {
        ST_INTEGRATE = 1'b0,
        ST_REFRACT   = 1'b1
    } lif_state_e;

    localparam int unsigned DEF_N_IN           = 2;
    localparam int unsigned DEF_W_WIDTH        = 4;
    localparam int unsigned DEF_V_WIDTH        = 8;
    localparam int unsigned DEF_LEAK_SHIFT     = 3;
    localparam int unsigned DEF_REFRACT_CYCLES = 3;

    // Unsigned add clamped to the largest value representable in 'width' bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] s;
        logic [32:0] max_val;
        s       = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (s > max_val) ? max_val[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/spike_weight_sum.sv
// Combinational sum of the weights whose spike line is active this cycle.
module spike_weight_sum #(
    parameter int unsigned N_IN      = 2,
    parameter int unsigned W_WIDTH   = 4,
    parameter int unsigned SUM_WIDTH = 10
) (
    input  logic [N_IN-1:0]         spike_in,
    input  logic [N_IN*W_WIDTH-1:0] weight_in,
    output logic [SUM_WIDTH-1:0]    sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) begin
                sum = sum + SUM_WIDTH'(weight_in[i*W_WIDTH +: W_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift leak, saturating integrate, one-cycle fire pulse and
// a fixed-length refractory hold.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int unsigned N_IN           = DEF_N_IN,
    parameter int unsigned W_WIDTH        = DEF_W_WIDTH,
    parameter int unsigned V_WIDTH        = DEF_V_WIDTH,
    parameter int unsigned LEAK_SHIFT     = DEF_LEAK_SHIFT,
    parameter int unsigned REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_IN-1:0]           spike_in,
    input  logic [N_IN*W_WIDTH-1:0]   weight_in,
    input  logic [V_WIDTH-1:0]        threshold,
    output logic                      spike_out,
    output logic [V_WIDTH-1:0]        potential,
    output logic                      refractory
);

    localparam int unsigned S_WIDTH = V_WIDTH + $clog2(N_IN) + 1;
    localparam int unsigned CNT_W   = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    lif_state_e         state_q, state_d;
    logic [V_WIDTH-1:0] pot_q, pot_d;
    logic               spike_q, spike_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [S_WIDTH-1:0] wsum;
    logic [V_WIDTH-1:0] leaked;
    logic [V_WIDTH-1:0] sum_sat;

    spike_weight_sum #(
        .N_IN      (N_IN),
        .W_WIDTH   (W_WIDTH),
        .SUM_WIDTH (S_WIDTH)
    ) u_sum (
        .spike_in  (spike_in),
        .weight_in (weight_in),
        .sum       (wsum)
    );

    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        leaked  = pot_q - (pot_q >> LEAK_SHIFT);
        sum_sat = V_WIDTH'(sat_add(32'(leaked), 32'(wsum), V_WIDTH));
        if (enable) begin
            unique case (state_q)
                ST_INTEGRATE: begin
                    if (sum_sat >= threshold) begin
                        spike_d = 1'b1;
                        pot_d   = '0;
                        if (REFRACT_CYCLES > 0) begin
                            state_d = ST_REFRACT;
                            cnt_d   = CNT_W'(REFRACT_CYCLES);
                        end
                    end else begin
                        pot_d = sum_sat;
                    end
                end
                ST_REFRACT: begin
                    // Spikes are ignored; leave after the last counted enabled cycle.
                    pot_d = '0;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_INTEGRATE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INTEGRATE;
            pot_q   <= '0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
        end
    end

    assign spike_out  = spike_q;
    assign potential  = pot_q;
    assign refractory = (state_q == ST_REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench: three neuron variants share stimulus and are compared every cycle
// against an arithmetic model, with directed scenarios pinning literal values.
module tb_lif_neuron;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] spike_in = '0;
    logic [7:0] weight_in = '0;
    logic [7:0] threshold = '0;
    bit         clk_run = 1'b0;

    logic [NDUT-1:0] spike_out;
    logic [NDUT-1:0] refractory;
    logic [7:0]      potential [NDUT];

    int n_checks = 0;
    int n_err = 0;

    // Variant 0: defaults, 1: no leak (shift 8), 2: no refractory period.
    int leaks [NDUT] = '{3, 8, 3};
    int refrs [NDUT] = '{3, 3, 0};

    int m_v    [NDUT];
    int m_left [NDUT];
    int m_spk  [NDUT];
    int s;

    lif_neuron #(.LEAK_SHIFT(3), .REFRACT_CYCLES(3)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .weight_in(weight_in),
        .threshold(threshold), .spike_out(spike_out[0]), .potential(potential[0]),
        .refractory(refractory[0])
    );
    lif_neuron #(.LEAK_SHIFT(8), .REFRACT_CYCLES(3)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .weight_in(weight_in),
        .threshold(threshold), .spike_out(spike_out[1]), .potential(potential[1]),
        .refractory(refractory[1])
    );
    lif_neuron #(.LEAK_SHIFT(3), .REFRACT_CYCLES(0)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .weight_in(weight_in),
        .threshold(threshold), .spike_out(spike_out[2]), .potential(potential[2]),
        .refractory(refractory[2])
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    function automatic int wsum(input logic [1:0] sp, input logic [7:0] w);
        int r;
        r = 0;
        if (sp[0]) r += int'(w[3:0]);
        if (sp[1]) r += int'(w[7:4]);
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NDUT; i++) begin
                m_v[i] = 0; m_left[i] = 0; m_spk[i] = 0;
            end
        end else if (enable) begin
            for (int i = 0; i < NDUT; i++) begin
                if (m_left[i] > 0) begin
                    m_left[i] -= 1; m_v[i] = 0; m_spk[i] = 0;
                end else begin
                    s = m_v[i] - (m_v[i] >> leaks[i]) + wsum(spike_in, weight_in);
                    if (s > 255) s = 255;
                    if (s >= int'(threshold)) begin
                        m_spk[i] = 1; m_v[i] = 0; m_left[i] = refrs[i];
                    end else begin
                        m_v[i] = s; m_spk[i] = 0;
                    end
                end
            end
        end else begin
            for (int i = 0; i < NDUT; i++) m_spk[i] = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clk_run && !reset) begin
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("spike_out[%0d]", i), int'(spike_out[i]), m_spk[i]);
                chk($sformatf("potential[%0d]", i), int'(potential[i]), m_v[i]);
                chk($sformatf("refractory[%0d]", i), int'(refractory[i]), int'(m_left[i] > 0));
            end
        end
    end

    task automatic step(input bit en, input logic [1:0] sp, input logic [3:0] w1,
                        input logic [3:0] w0, input logic [7:0] th);
        enable = en; spike_in = sp; weight_in = {w1, w0}; threshold = th;
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after an edge; reset pulse lies wholly between edges.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    int pot_seq [4] = '{5, 10, 14, 18};
    int leak_seq [7] = '{30, 57, 80, 100, 88, 77, 68};

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("reset potential", int'(potential[0]), 0);
        chk("reset spike_out", int'(spike_out[0]), 0);
        chk("reset refractory", int'(refractory[0]), 0);
        clk_run = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2'b00, 4'd0, 4'd0, 8'd20);
            chk("idle potential", int'(potential[0]), 0);
        end

        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'b01, 4'd0, 4'd5, 8'd20);
            chk("integrate potential", int'(potential[0]), pot_seq[k]);
        end
        step(1'b1, 2'b01, 4'd0, 4'd5, 8'd20);
        chk("fire spike_out", int'(spike_out[0]), 1);
        chk("fire potential", int'(potential[0]), 0);
        chk("fire refractory", int'(refractory[0]), 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b11, 4'd10, 4'd5, 8'd20);
            chk("refract potential", int'(potential[0]), 0);
            chk("refract spike_out", int'(spike_out[0]), 0);
            chk("refract flag", int'(refractory[0]), (k < 2) ? 1 : 0);
        end
        step(1'b1, 2'b11, 4'd10, 4'd5, 8'd20);
        chk("post-refract potential", int'(potential[0]), 15);

        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(1'b1, (k < 4) ? 2'b11 : 2'b00, 4'd15, 4'd15, 8'd255);
            chk("leak potential", int'(potential[0]), leak_seq[k]);
        end

        do_reset();
        step(1'b1, 2'b11, 4'd15, 4'd15, 8'd255);
        step(1'b1, 2'b11, 4'd15, 4'd15, 8'd255);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'b11, 4'd15, 4'd15, 8'd255);
            chk("hold potential", int'(potential[0]), 57);
            chk("hold spike_out", int'(spike_out[0]), 0);
        end

        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 2'b11, 4'd15, 4'd15, 8'd255);
            chk("sat potential", int'(potential[1]), 30 * k);
        end
        step(1'b1, 2'b11, 4'd15, 4'd15, 8'd255);
        chk("sat spike_out", int'(spike_out[1]), 1);
        chk("sat potential clear", int'(potential[1]), 0);
        chk("sat refractory", int'(refractory[1]), 1);
        #1 reset = 1'b1;
        #1;
        chk("async reset refractory", int'(refractory[1]), 0);
        chk("async reset potential", int'(potential[1]), 0);
        reset = 1'b0;
        step(1'b1, 2'b11, 4'd15, 4'd15, 8'd255);
        chk("restart potential", int'(potential[1]), 30);
        chk("restart refractory", int'(refractory[1]), 0);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b00, 4'd0, 4'd0, 8'd0);
            chk("th0 no-refract spike_out", int'(spike_out[2]), 1);
        end

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 9) != 0, 2'($urandom), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(40, 200)));
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
Clocked leaky integrate-and-fire neuron that sits directly downstream of the synapse stage. It consumes per-input spike lines plus per-synapse weights and accumulates a membrane potential with shift-based leak. It emits a one-cycle spike when the potential reaches threshold, then enforces a refractory period. It replaces the free-running neuron instances in the top-level network, so synapse outputs can close the loop.

Parameters:
N_IN, 2, number of synaptic inputs
W_WIDTH, 4, unsigned weight width per input
V_WIDTH, 8, membrane potential / threshold width (unsigned)
LEAK_SHIFT, 3, leak = V >> LEAK_SHIFT per enabled integrate cycle; legal range 1..V_WIDTH
REFRACT_CYCLES, 3, cycles held in refractory after a fire; 0 = none

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
enable  in  1  advance state when 1; freeze when 0
spike_in  in  N_IN  spike lines from synapses, sampled on clk
weight_in  in  N_IN*W_WIDTH  packed unsigned weights; input i at bits [i*W_WIDTH +: W_WIDTH]
threshold  in  V_WIDTH  fire threshold, sampled on clk
spike_out  out  1  registered one-cycle fire pulse
potential  out  V_WIDTH  registered membrane potential
refractory  out  1  high while in REFRACT state

Behaviour:
- Reset (async, any time, including mid-refractory): potential=0, spike_out=0, refractory=0, state=INTEGRATE, refractory counter=0.
- States: INTEGRATE, REFRACT. All outputs registered.
- enable=0: state, potential and counter hold; spike_out<=0 on the next edge.
- INTEGRATE, enable=1, each edge:
  - sum = V - (V >> LEAK_SHIFT) + Σ weight_i over i where spike_in[i]=1.
  - Internal width is V_WIDTH + clog2(N_IN) + 1. sum saturates at 2^V_WIDTH-1 before compare.
  - If sum >= threshold: spike_out<=1, potential<=0. If REFRACT_CYCLES>0, go to REFRACT with counter<=REFRACT_CYCLES. Otherwise stay in INTEGRATE.
  - Else: potential<=sum, spike_out<=0.
- REFRACT, enable=1, each edge:
  - spike_in ignored, potential held 0, spike_out<=0, counter decrements.
  - When counter reaches 0, return to INTEGRATE. The REFRACT state therefore lasts exactly REFRACT_CYCLES enabled cycles.
- refractory = (state==REFRACT).
- Latency: a spike sampled at edge k affects potential and spike_out at edge k (visible after edge k).
- threshold=0: fires on every enabled INTEGRATE cycle. With REFRACT_CYCLES=0, spike_out stays high continuously. This is legal.
- Simultaneous spikes on all inputs sum in one cycle; there is no arbitration.
- Leak on V=0 yields 0; there is no underflow.

Decomposition:
- Package lif_pkg: state enum (ST_INTEGRATE, ST_REFRACT), default width constants, saturating-add helper function.
- Sub-module spike_weight_sum: combinational gated adder tree over N_IN inputs. It outputs the unsaturated sum width; lif_neuron instantiates it once.

Test Plan:
- Reset/idle: assert reset with clk stopped -> potential=0, spike_out=0, refractory=0 immediately. Release with spike_in=0 for 5 cycles -> potential stays 0.
- Integrate and fire (defaults, threshold=20, weight0=5, spike_in=01 every cycle):
  - potential after each edge: 5, 10, 14, 18.
  - 5th edge: sum=21 -> spike_out=1 for one cycle, potential=0.
- Refractory (continuing from the fire):
  - next 3 enabled edges: refractory=1, potential=0, spike_out=0 despite spike_in=11.
  - 4th edge: integrates again, potential=15 with weight1=10, weight0=5.
- Leak (threshold=255, weights 15/15, spike_in=11):
  - potential 30, 57, 80, 100.
  - then spike_in=00: potential 88, 77, 68.
- Saturation (instance LEAK_SHIFT=8, threshold=255, weights 15/15, spike_in=11):
  - potential 30..240 over 8 edges.
  - 9th edge: raw 270 clamps to 255 -> spike_out=1, potential=0.
- Enable/reset mid-operation:
  - enable=0 at potential=57 for 4 cycles -> potential holds 57, spike_out=0.
  - async reset pulse mid-REFRACT (between edges) -> refractory drops to 0 immediately.
  - after release: starts in INTEGRATE.
